// File: rtl/wb_pkg.sv
// Shared constants, source ids and request payload type for the writeback arbiter.
package wb_pkg;

  localparam int unsigned NUM_SRC   = 3;
  localparam int unsigned PREG_W    = 7;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned ROB_W     = 4;
  localparam int unsigned SRC_IDX_W = 2;

  typedef enum logic [SRC_IDX_W-1:0] {
    SRC_ALU1 = 2'd0,
    SRC_ALU2 = 2'd1,
    SRC_MEM  = 2'd2
  } src_e;

  typedef struct packed {
    logic [PREG_W-1:0] preg;
    logic [DATA_W-1:0] data;
    logic [ROB_W-1:0]  rob;
    logic              wen;
  } wb_req_t;

  // Advance a source index modulo NUM_SRC.
  function automatic logic [SRC_IDX_W-1:0] wrap_inc(input logic [SRC_IDX_W-1:0] idx);
    return (idx == SRC_IDX_W'(NUM_SRC - 1)) ? '0 : idx + SRC_IDX_W'(1);
  endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Execute-stage result handshake plus regfile write / ROB completion bus.
interface wb_arbiter_if;
  import wb_pkg::*;

  logic [NUM_SRC-1:0]        src_valid;
  logic [NUM_SRC-1:0]        src_ready;
  logic [NUM_SRC*PREG_W-1:0] src_preg;
  logic [NUM_SRC*DATA_W-1:0] src_data;
  logic [NUM_SRC*ROB_W-1:0]  src_rob;
  logic [NUM_SRC-1:0]        src_wen;

  logic              wr_en_1;
  logic              wr_en_2;
  logic [PREG_W-1:0] wr_rd_1;
  logic [PREG_W-1:0] wr_rd_2;
  logic [DATA_W-1:0] wr_data_1;
  logic [DATA_W-1:0] wr_data_2;
  logic              cmp_valid_1;
  logic              cmp_valid_2;
  logic [ROB_W-1:0]  cmp_rob_1;
  logic [ROB_W-1:0]  cmp_rob_2;

  // Arbiter side.
  modport slave (
    input  src_valid, src_preg, src_data, src_rob, src_wen,
    output src_ready,
    output wr_en_1, wr_en_2, wr_rd_1, wr_rd_2, wr_data_1, wr_data_2,
    output cmp_valid_1, cmp_valid_2, cmp_rob_1, cmp_rob_2
  );

  // Functional-unit / consumer side.
  modport master (
    output src_valid, src_preg, src_data, src_rob, src_wen,
    input  src_ready,
    input  wr_en_1, wr_en_2, wr_rd_1, wr_rd_2, wr_data_1, wr_data_2,
    input  cmp_valid_1, cmp_valid_2, cmp_rob_1, cmp_rob_2
  );

endinterface

// File: rtl/rr_pick2.sv
// Combinational round-robin picker: up to two valid sources, scanned from rr_i upward.
module rr_pick2
  import wb_pkg::*;
(
  input  logic [NUM_SRC-1:0]   valid_i,
  input  logic [SRC_IDX_W-1:0] rr_i,
  output logic [NUM_SRC-1:0]   grant_o,
  output logic                 slot1_vld_o,
  output logic [SRC_IDX_W-1:0] slot1_idx_o,
  output logic                 slot2_vld_o,
  output logic [SRC_IDX_W-1:0] slot2_idx_o
);

  logic [SRC_IDX_W-1:0] idx;

  always_comb begin
    grant_o     = '0;
    slot1_vld_o = 1'b0;
    slot1_idx_o = rr_i;
    slot2_vld_o = 1'b0;
    slot2_idx_o = rr_i;
    idx         = rr_i;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (valid_i[idx]) begin
        if (!slot1_vld_o) begin
          slot1_vld_o  = 1'b1;
          slot1_idx_o  = idx;
          grant_o[idx] = 1'b1;
        end else if (!slot2_vld_o) begin
          slot2_vld_o  = 1'b1;
          slot2_idx_o  = idx;
          grant_o[idx] = 1'b1;
        end
      end
      idx = wrap_inc(idx);
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Dual-port writeback arbiter: round-robin grants two of three FU results per cycle.
// Define WB_PERF_EN to add saturating perf_writes / perf_stalls counters.
module wb_arbiter
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  wb_arbiter_if.slave bus
`ifdef WB_PERF_EN
  ,
  output logic [31:0] perf_writes,
  output logic [31:0] perf_stalls
`endif
);

  wb_req_t req [NUM_SRC];

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req[i].preg = bus.src_preg[i*PREG_W +: PREG_W];
      req[i].data = bus.src_data[i*DATA_W +: DATA_W];
      req[i].rob  = bus.src_rob[i*ROB_W +: ROB_W];
      req[i].wen  = bus.src_wen[i];
    end
  end

  logic [SRC_IDX_W-1:0] rr_q, rr_d;
  logic [NUM_SRC-1:0]   grant;
  logic                 s1_vld, s2_vld;
  logic [SRC_IDX_W-1:0] s1_idx, s2_idx;

  rr_pick2 u_pick (
    .valid_i     (bus.src_valid),
    .rr_i        (rr_q),
    .grant_o     (grant),
    .slot1_vld_o (s1_vld),
    .slot1_idx_o (s1_idx),
    .slot2_vld_o (s2_vld),
    .slot2_idx_o (s2_idx)
  );

  assign bus.src_ready = grant;

  logic              wr_en_1_q, wr_en_1_d, wr_en_2_q, wr_en_2_d;
  logic [PREG_W-1:0] wr_rd_1_q, wr_rd_2_q;
  logic [DATA_W-1:0] wr_data_1_q, wr_data_2_q;
  logic              cmp_valid_1_q, cmp_valid_2_q;
  logic [ROB_W-1:0]  cmp_rob_1_q, cmp_rob_2_q;

  always_comb begin
    wr_en_1_d = s1_vld && req[s1_idx].wen && (req[s1_idx].preg != '0);
    // A duplicate preg on slot 2 would race slot 1's write; slot 1 wins.
    wr_en_2_d = s2_vld && req[s2_idx].wen && (req[s2_idx].preg != '0) &&
                !(wr_en_1_d && (req[s2_idx].preg == req[s1_idx].preg));
    rr_d = rr_q;
    if (s1_vld) begin
      rr_d = wrap_inc(s2_vld ? s2_idx : s1_idx);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q          <= SRC_ALU1;
      wr_en_1_q     <= 1'b0;
      wr_en_2_q     <= 1'b0;
      wr_rd_1_q     <= '0;
      wr_rd_2_q     <= '0;
      wr_data_1_q   <= '0;
      wr_data_2_q   <= '0;
      cmp_valid_1_q <= 1'b0;
      cmp_valid_2_q <= 1'b0;
      cmp_rob_1_q   <= '0;
      cmp_rob_2_q   <= '0;
    end else begin
      rr_q          <= rr_d;
      wr_en_1_q     <= wr_en_1_d;
      wr_en_2_q     <= wr_en_2_d;
      cmp_valid_1_q <= s1_vld;
      cmp_valid_2_q <= s2_vld;
      if (s1_vld) begin
        wr_rd_1_q   <= req[s1_idx].preg;
        wr_data_1_q <= req[s1_idx].data;
        cmp_rob_1_q <= req[s1_idx].rob;
      end
      if (s2_vld) begin
        wr_rd_2_q   <= req[s2_idx].preg;
        wr_data_2_q <= req[s2_idx].data;
        cmp_rob_2_q <= req[s2_idx].rob;
      end
    end
  end

  assign bus.wr_en_1     = wr_en_1_q;
  assign bus.wr_en_2     = wr_en_2_q;
  assign bus.wr_rd_1     = wr_rd_1_q;
  assign bus.wr_rd_2     = wr_rd_2_q;
  assign bus.wr_data_1   = wr_data_1_q;
  assign bus.wr_data_2   = wr_data_2_q;
  assign bus.cmp_valid_1 = cmp_valid_1_q;
  assign bus.cmp_valid_2 = cmp_valid_2_q;
  assign bus.cmp_rob_1   = cmp_rob_1_q;
  assign bus.cmp_rob_2   = cmp_rob_2_q;

`ifdef WB_PERF_EN
  logic [31:0] perf_writes_q, perf_stalls_q;
  logic [32:0] writes_sum, stalls_sum;
  logic [1:0]  wr_cnt;
  logic        stall;

  always_comb begin
    wr_cnt     = {1'b0, wr_en_1_d} + {1'b0, wr_en_2_d};
    stall      = |(bus.src_valid & ~grant);
    writes_sum = {1'b0, perf_writes_q} + 33'(wr_cnt);
    stalls_sum = {1'b0, perf_stalls_q} + 33'(stall);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_writes_q <= '0;
      perf_stalls_q <= '0;
    end else begin
      perf_writes_q <= writes_sum[32] ? '1 : writes_sum[31:0];
      perf_stalls_q <= stalls_sum[32] ? '1 : stalls_sum[31:0];
    end
  end

  assign perf_writes = perf_writes_q;
  assign perf_stalls = perf_stalls_q;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: grant order, latency, preg-0 / duplicate rules, reset.
module tb_wb_arbiter;
  import wb_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  wb_arbiter_if bus ();

`ifdef WB_PERF_EN
  logic [31:0] perf_writes, perf_stalls;
  wb_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.slave),
    .perf_writes (perf_writes),
    .perf_stalls (perf_stalls)
  );
`else
  wb_arbiter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [PREG_W-1:0] preg,
                         input logic [DATA_W-1:0] data, input logic [ROB_W-1:0] rob,
                         input logic wen);
    bus.src_preg[i*PREG_W +: PREG_W] = preg;
    bus.src_data[i*DATA_W +: DATA_W] = data;
    bus.src_rob[i*ROB_W +: ROB_W]    = rob;
    bus.src_wen[i]                   = wen;
  endtask

  task automatic do_reset();
    bus.src_valid = '0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [3:0] strobes;
    bus.src_valid = 3'b001;
    bus.src_preg  = '0;
    bus.src_data  = '0;
    bus.src_rob   = '0;
    bus.src_wen   = '0;
    #1;
    n_checks++;
    if (bus.src_ready !== 3'b001)
      $display("FAIL reset_ready: got %b want %b", bus.src_ready, 3'b001);
    else n_pass++;
    step();
    step();
    bus.src_valid = '0;
    reset = 1'b0;
    n_checks++;
    if ({bus.wr_rd_1, bus.wr_data_1, bus.cmp_rob_1, bus.wr_rd_2, bus.wr_data_2,
         bus.cmp_rob_2} !== '0)
      $display("FAIL reset_fields: outputs not zero after reset");
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      step();
      strobes = {bus.wr_en_1, bus.wr_en_2, bus.cmp_valid_1, bus.cmp_valid_2};
      n_checks++;
      if (strobes !== 4'b0000)
        $display("FAIL idle_strobes cycle %0d: got %b want 0000", c, strobes);
      else n_pass++;
    end
    n_checks++;
    if (dut.rr_q !== 2'd0) $display("FAIL idle_rr: got %0d want 0", dut.rr_q);
    else n_pass++;
  endtask

  task automatic test_single();
    set_src(0, 7'd5, 32'h1234, 4'd3, 1'b1);
    bus.src_valid = 3'b001;
    #1;
    n_checks++;
    if (bus.src_ready !== 3'b001)
      $display("FAIL single_ready: got %b want 001", bus.src_ready);
    else n_pass++;
    step();
    bus.src_valid = '0;
    n_checks++;
    if ({bus.wr_en_1, bus.wr_rd_1, bus.wr_data_1, bus.cmp_valid_1, bus.cmp_rob_1,
         bus.wr_en_2, bus.cmp_valid_2} !== {1'b1, 7'd5, 32'h1234, 1'b1, 4'd3, 1'b0, 1'b0})
      $display("FAIL single_out: en1=%b rd1=%0d d1=%h cv1=%b rob1=%0d en2=%b cv2=%b",
               bus.wr_en_1, bus.wr_rd_1, bus.wr_data_1, bus.cmp_valid_1, bus.cmp_rob_1,
               bus.wr_en_2, bus.cmp_valid_2);
    else n_pass++;
    n_checks++;
    if (dut.rr_q !== 2'd1) $display("FAIL single_rr: got %0d want 1", dut.rr_q);
    else n_pass++;
  endtask

  task automatic test_all_three();
    logic [2:0] exp_ready [3];
    logic [6:0] exp_rd1   [3];
    logic [6:0] exp_rd2   [3];
    logic [1:0] exp_rr    [3];
    exp_ready = '{3'b011, 3'b101, 3'b110};
    exp_rd1   = '{7'd10, 7'd12, 7'd11};
    exp_rd2   = '{7'd11, 7'd10, 7'd12};
    exp_rr    = '{2'd2, 2'd1, 2'd0};
    do_reset();
    for (int i = 0; i < 3; i++) set_src(i, 7'(10 + i), 32'hA0 + i, 4'(4 + i), 1'b1);
    bus.src_valid = 3'b111;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.src_ready !== exp_ready[c])
        $display("FAIL rr_ready cycle %0d: got %b want %b", c, bus.src_ready, exp_ready[c]);
      else n_pass++;
      step();
      n_checks++;
      if ({bus.wr_en_1, bus.wr_en_2, bus.wr_rd_1, bus.wr_rd_2, dut.rr_q} !==
          {2'b11, exp_rd1[c], exp_rd2[c], exp_rr[c]})
        $display("FAIL rr_out cycle %0d: en=%b%b rd1=%0d/%0d rd2=%0d/%0d rr=%0d/%0d", c,
                 bus.wr_en_1, bus.wr_en_2, bus.wr_rd_1, exp_rd1[c], bus.wr_rd_2, exp_rd2[c],
                 dut.rr_q, exp_rr[c]);
      else n_pass++;
    end
    bus.src_valid = '0;
  endtask

  task automatic test_preg0();
    set_src(0, 7'd0, 32'h55, 4'd1, 1'b1);
    set_src(2, 7'd20, 32'h66, 4'd6, 1'b0);
    bus.src_valid = 3'b101;
    step();
    bus.src_valid = '0;
    n_checks++;
    if ({bus.cmp_valid_1, bus.cmp_valid_2, bus.wr_en_1, bus.wr_en_2, bus.cmp_rob_1,
         bus.cmp_rob_2} !== {4'b1100, 4'd1, 4'd6})
      $display("FAIL preg0: cv=%b%b en=%b%b rob1=%0d rob2=%0d want cv=11 en=00 rob 1/6",
               bus.cmp_valid_1, bus.cmp_valid_2, bus.wr_en_1, bus.wr_en_2,
               bus.cmp_rob_1, bus.cmp_rob_2);
    else n_pass++;
  endtask

  task automatic test_same_preg();
    set_src(0, 7'd9, 32'd7, 4'd2, 1'b1);
    set_src(1, 7'd9, 32'd8, 4'd3, 1'b1);
    bus.src_valid = 3'b011;
    step();
    bus.src_valid = '0;
    n_checks++;
    if ({bus.wr_en_1, bus.wr_data_1, bus.wr_en_2, bus.cmp_valid_1, bus.cmp_valid_2} !==
        {1'b1, 32'd7, 1'b0, 1'b1, 1'b1})
      $display("FAIL same_preg: en1=%b d1=%0d en2=%b cv=%b%b want 1 7 0 11",
               bus.wr_en_1, bus.wr_data_1, bus.wr_en_2, bus.cmp_valid_1, bus.cmp_valid_2);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    set_src(0, 7'd30, 32'h30, 4'd8, 1'b1);
    set_src(1, 7'd31, 32'h31, 4'd9, 1'b1);
    bus.src_valid = 3'b011;
    step();
    n_checks++;
    if ({bus.wr_en_1, bus.wr_en_2} !== 2'b11)
      $display("FAIL mid_pre: en=%b%b want 11", bus.wr_en_1, bus.wr_en_2);
    else n_pass++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.src_valid = '0;
    n_checks++;
    if ({bus.wr_en_1, bus.wr_en_2, bus.cmp_valid_1, bus.cmp_valid_2, bus.wr_rd_1,
         bus.wr_data_2, dut.rr_q} !== '0)
      $display("FAIL mid_reset: en=%b%b cv=%b%b rd1=%0d d2=%h rr=%0d want all 0",
               bus.wr_en_1, bus.wr_en_2, bus.cmp_valid_1, bus.cmp_valid_2, bus.wr_rd_1,
               bus.wr_data_2, dut.rr_q);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
`ifdef WB_PERF_EN
    n_checks++;
    if ({perf_writes, perf_stalls} !== 64'd0)
      $display("FAIL perf_reset: writes=%0d stalls=%0d want 0 0", perf_writes, perf_stalls);
    else n_pass++;
`endif
    bus.src_valid = 3'b001;
    for (int c = 0; c < 4; c++) begin
      set_src(0, 7'(40 + c), 32'hB00 + c, 4'(c), 1'b1);
      step();
      n_checks++;
      if ({bus.wr_en_1, bus.wr_rd_1, bus.wr_data_1} !== {1'b1, 7'(40 + c), 32'hB00 + c})
        $display("FAIL b2b cycle %0d: en=%b rd=%0d data=%h want 1 %0d %h", c, bus.wr_en_1,
                 bus.wr_rd_1, bus.wr_data_1, 40 + c, 32'hB00 + c);
      else n_pass++;
    end
    bus.src_valid = '0;
`ifdef WB_PERF_EN
    n_checks++;
    if ({perf_writes, perf_stalls} !== {32'd4, 32'd0})
      $display("FAIL perf_count: writes=%0d stalls=%0d want 4 0", perf_writes, perf_stalls);
    else n_pass++;
`endif
    step();
    n_checks++;
    if ({bus.wr_en_1, bus.cmp_valid_1} !== 2'b00)
      $display("FAIL b2b_drop: en=%b cv=%b want 00", bus.wr_en_1, bus.cmp_valid_1);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_all_three();
    test_preg0();
    test_same_preg();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
